// File: rtl/instr_exec_unit.sv
// Execution unit that walks a run of instruction-register entries, executes each opcode
// (iterative restoring divider for DIV/MOD) and hands every result out on a valid/ready channel.
module instr_exec_unit #(
  parameter int OP_W   = 32,
  parameter int ADDR_W = 5,
  parameter int RES_W  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_ptr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] read_pointer,
  input  logic [2:0]        iw_opcode,
  input  logic [OP_W-1:0]   iw_operand_a,
  input  logic [OP_W-1:0]   iw_operand_b,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_index,
  output logic [2:0]        res_opcode,
  output logic [OP_W-1:0]   res_operand_a,
  output logic [OP_W-1:0]   res_operand_b,
  output logic [RES_W-1:0]  res_result,
  output logic              res_div0,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Result channel: a result transfers on a rising edge where res_valid && res_ready;
  // while res_valid is high without res_ready, every res_* output holds its value.

  localparam int CNT_W = $clog2(OP_W) + 1;

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_OUT   = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [2:0]         opc_q, opc_d;
  logic [OP_W-1:0]    opa_q, opa_d;
  logic [OP_W-1:0]    opb_q, opb_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               div0_q, div0_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [OP_W-1:0]    quo_q, quo_d;
  logic [OP_W-1:0]    prem_q, prem_d;
  logic [OP_W-1:0]    dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;

  logic [RES_W-1:0]   sa, sb, alu_res;
  logic [RES_W-1:0]   q_ext, r_ext;
  logic [OP_W-1:0]    a_mag, b_mag;
  logic [OP_W:0]      shifted, diff;
  logic               is_div;

  assign sa     = {{(RES_W-OP_W){opa_q[OP_W-1]}}, opa_q};
  assign sb     = {{(RES_W-OP_W){opb_q[OP_W-1]}}, opb_q};
  assign q_ext  = {{(RES_W-OP_W){1'b0}}, quo_q};
  assign r_ext  = {{(RES_W-OP_W){1'b0}}, prem_q};
  // Magnitude of -2^OP_W-1 is still exact when read back as unsigned.
  assign a_mag  = iw_operand_a[OP_W-1] ? -iw_operand_a : iw_operand_a;
  assign b_mag  = iw_operand_b[OP_W-1] ? -iw_operand_b : iw_operand_b;
  assign is_div = (opc_q[2:1] == 2'b11);

  // One restoring step: quo_q shifts the dividend out MSB-first while quotient bits enter.
  assign shifted = {prem_q, quo_q[OP_W-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    alu_res = '0;
    case (opc_q)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = sa;
      OP_PASSB: alu_res = sb;
      OP_ADD:   alu_res = sa + sb;
      OP_SUB:   alu_res = sa - sb;
      OP_MULT:  alu_res = sa * sb;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    opc_d    = opc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    div0_d   = div0_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    quo_d    = quo_q;
    prem_d   = prem_q;
    dvsr_d   = dvsr_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d = first_ptr;
          rem_d = count;
          if (count == '0) done_d  = 1'b1;
          else             state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        idx_d   = ptr_q;
        opc_d   = iw_opcode;
        opa_d   = iw_operand_a;
        opb_d   = iw_operand_b;
        quo_d   = a_mag;
        dvsr_d  = b_mag;
        prem_d  = '0;
        dcnt_d  = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!is_div) begin
          result_d = alu_res;
          div0_d   = 1'b0;
          valid_d  = 1'b1;
          state_d  = S_OUT;
        end else if (opb_q == '0) begin
          result_d = '0;
          div0_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = S_OUT;
        end else if (dcnt_q != CNT_W'(OP_W)) begin
          if (!diff[OP_W]) begin
            prem_d = diff[OP_W-1:0];
            quo_d  = {quo_q[OP_W-2:0], 1'b1};
          end else begin
            prem_d = shifted[OP_W-1:0];
            quo_d  = {quo_q[OP_W-2:0], 1'b0};
          end
          dcnt_d = dcnt_q + 1'b1;
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          if (opc_q == OP_DIV)
            result_d = (opa_q[OP_W-1] ^ opb_q[OP_W-1]) ? -q_ext : q_ext;
          else
            result_d = opa_q[OP_W-1] ? -r_ext : r_ext;
          div0_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          if (rem_q > (ADDR_W+1)'(1)) begin
            ptr_d   = ptr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      opc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      div0_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      quo_q    <= '0;
      prem_q   <= '0;
      dvsr_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      opc_q    <= opc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      div0_q   <= div0_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      quo_q    <= quo_d;
      prem_q   <= prem_d;
      dvsr_q   <= dvsr_d;
      dcnt_q   <= dcnt_d;
    end
  end

  assign read_pointer  = ptr_q;
  assign busy          = (state_q != S_IDLE);
  assign res_valid     = valid_q;
  assign res_index     = idx_q;
  assign res_opcode    = opc_q;
  assign res_operand_a = opa_q;
  assign res_operand_b = opb_q;
  assign res_result    = result_q;
  assign res_div0      = div0_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit: a memory model plays the instruction register,
// expected results go into a queue and a negedge monitor checks each accepted result.
module tb_instr_exec_unit;

  localparam int OP_W   = 32;
  localparam int ADDR_W = 5;
  localparam int RES_W  = 64;

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] first_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] read_pointer;
  logic [2:0]        iw_opcode;
  logic [OP_W-1:0]   iw_operand_a;
  logic [OP_W-1:0]   iw_operand_b;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_index;
  logic [2:0]        res_opcode;
  logic [OP_W-1:0]   res_operand_a;
  logic [OP_W-1:0]   res_operand_b;
  logic [RES_W-1:0]  res_result;
  logic              res_div0;
  logic              done;
  logic [2:0]        dbg_state;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [2:0]        op;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [RES_W-1:0]  res;
    logic              div0;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  exp_t             mon_e;
  int               checks    = 0;
  int               failures  = 0;
  int               done_cnt  = 0;
  int               done_base = 0;

  logic [2:0]      mem_op[32];
  logic [OP_W-1:0] mem_a[32];
  logic [OP_W-1:0] mem_b[32];

  assign iw_opcode    = mem_op[read_pointer];
  assign iw_operand_a = mem_a[read_pointer];
  assign iw_operand_b = mem_b[read_pointer];

  instr_exec_unit #(.OP_W(OP_W), .ADDR_W(ADDR_W), .RES_W(RES_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .first_ptr    (first_ptr),
    .count        (count),
    .read_pointer (read_pointer),
    .iw_opcode    (iw_opcode),
    .iw_operand_a (iw_operand_a),
    .iw_operand_b (iw_operand_b),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_index    (res_index),
    .res_opcode   (res_opcode),
    .res_operand_a(res_operand_a),
    .res_operand_b(res_operand_b),
    .res_result   (res_result),
    .res_div0     (res_div0),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is popped against the expected queue
  always @(negedge clk) begin
    if (reset_n && done) done_cnt++;
    if (reset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual index=%0d result=0x%0h expected=none", res_index, res_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_index",     128'(res_index),     128'(mon_e.idx));
        check("read_pointer",  128'(read_pointer),  128'(mon_e.idx));
        check("res_opcode",    128'(res_opcode),    128'(mon_e.op));
        check("res_operand_a", 128'(res_operand_a), 128'(mon_e.a));
        check("res_operand_b", 128'(res_operand_b), 128'(mon_e.b));
        check("res_result",    128'(res_result),    128'(mon_e.res));
        check("res_div0",      128'(res_div0),      128'(mon_e.div0));
      end
    end
  end

  // Driver tasks
  task automatic set_entry(input int idx, input logic [2:0] op, input logic [OP_W-1:0] a,
                           input logic [OP_W-1:0] b);
    mem_op[idx] = op;
    mem_a[idx]  = a;
    mem_b[idx]  = b;
  endtask

  task automatic expect_res(input int idx, input logic [RES_W-1:0] r, input logic d0);
    exp_t e;
    e.idx  = ADDR_W'(idx);
    e.op   = mem_op[idx];
    e.a    = mem_a[idx];
    e.b    = mem_b[idx];
    e.res  = r;
    e.div0 = d0;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [ADDR_W-1:0] fp, input logic [ADDR_W:0] cnt);
    @(negedge clk);
    first_ptr = fp;
    count     = cnt;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    done_base = done_cnt;
  endtask

  // Latency counts rising edges with the start-sampling edge as edge 1.
  task automatic measure_latency(input string name, input int exp_lat);
    int lat = 1;
    while (!res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, 128'(lat), 128'(exp_lat));
  endtask

  task automatic finish_run(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, 128'(done), 128'(1));
    @(posedge clk);
    #1;
    check({name, "_done_width"}, 128'(done), 128'(0));
    check({name, "_busy_after"}, 128'(busy), 128'(0));
    check({name, "_done_pulses"}, 128'(done_cnt - done_base), 128'(1));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_op[i] = OP_ZERO;
      mem_a[i]  = '0;
      mem_b[i]  = '0;
    end
    reset_n   = 1'b0;
    start     = 1'b0;
    first_ptr = '0;
    count     = '0;
    res_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_pointer", 128'(read_pointer), 128'(0));
    check("rst_busy",         128'(busy),         128'(0));
    check("rst_res_valid",    128'(res_valid),    128'(0));
    check("rst_done",         128'(done),         128'(0));
    check("rst_res_result",   128'(res_result),   128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Single ADD
    set_entry(0, OP_ADD, 32'd5, 32'd7);
    expect_res(0, 64'd12, 1'b0);
    run(5'd0, 6'd1);
    measure_latency("lat_add", 3);
    finish_run("t_add", 10);

    // Four entries with pointer wrap 30,31,0,1
    set_entry(30, OP_PASSA, 32'd9, 32'd1);
    set_entry(31, OP_PASSB, 32'd9, 32'd1);
    set_entry(0,  OP_SUB,   32'd3, 32'd10);
    set_entry(1,  OP_MULT,  -32'sd70000, 32'sd70000);
    expect_res(30, 64'd9, 1'b0);
    expect_res(31, 64'd1, 1'b0);
    expect_res(0,  -64'sd7, 1'b0);
    expect_res(1,  -64'sd4900000000, 1'b0);
    run(5'd30, 6'd4);
    finish_run("t_wrap", 40);
    check("t_wrap_queue_empty", 128'(exp_q.size()), 128'(0));

    // Division corner cases
    set_entry(2, OP_DIV, -32'sd17, 32'sd5);
    set_entry(3, OP_MOD, -32'sd17, 32'sd5);
    set_entry(4, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    set_entry(5, OP_DIV, 32'd8, 32'd0);
    set_entry(6, OP_MOD, 32'sd17, -32'sd5);
    set_entry(7, OP_DIV, 32'sd7, -32'sd2);
    set_entry(8, OP_MOD, 32'd5, 32'd0);
    set_entry(9, OP_MULT, 32'h8000_0000, 32'h8000_0000);

    expect_res(2, -64'sd3, 1'b0);
    run(5'd2, 6'd1);
    measure_latency("lat_div", 35);
    finish_run("t_div", 10);

    expect_res(3, -64'sd2, 1'b0);
    run(5'd3, 6'd1);
    finish_run("t_mod", 50);

    expect_res(4, 64'h0000_0000_8000_0000, 1'b0);
    run(5'd4, 6'd1);
    finish_run("t_div_min", 50);

    expect_res(5, 64'd0, 1'b1);
    run(5'd5, 6'd1);
    measure_latency("lat_div0", 3);
    finish_run("t_div0", 10);

    expect_res(6, 64'd2, 1'b0);
    expect_res(7, -64'sd3, 1'b0);
    expect_res(8, 64'd0, 1'b1);
    expect_res(9, 64'h4000_0000_0000_0000, 1'b0);
    run(5'd6, 6'd4);
    finish_run("t_mix", 150);

    // Backpressure: outputs hold and the pointer stays put
    res_ready = 1'b0;
    set_entry(10, OP_ADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_entry(11, OP_ZERO, 32'd3, 32'd4);
    expect_res(10, -64'sd2, 1'b0);
    expect_res(11, 64'd0, 1'b0);
    run(5'd10, 6'd2);
    measure_latency("lat_bp", 3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid",     128'(res_valid),     128'(1));
      check("bp_result",    128'(res_result),    128'(64'hFFFF_FFFF_FFFF_FFFE));
      check("bp_index",     128'(res_index),     128'(10));
      check("bp_read_ptr",  128'(read_pointer),  128'(10));
      check("bp_operand_a", 128'(res_operand_a), 128'(32'hFFFF_FFFF));
    end
    res_ready = 1'b1;
    finish_run("t_bp", 20);

    // Asynchronous reset in the middle of a division
    set_entry(12, OP_DIV, 32'd100, 32'd7);
    run(5'd12, 6'd1);
    repeat (12) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_read_pointer", 128'(read_pointer),  128'(0));
    check("mid_rst_busy",         128'(busy),          128'(0));
    check("mid_rst_res_valid",    128'(res_valid),     128'(0));
    check("mid_rst_res_index",    128'(res_index),     128'(0));
    check("mid_rst_operand_a",    128'(res_operand_a), 128'(0));
    check("mid_rst_opcode",       128'(res_opcode),    128'(0));
    check("mid_rst_done",         128'(done),          128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    set_entry(13, OP_ADD, 32'd1, 32'd2);
    expect_res(13, 64'd3, 1'b0);
    run(5'd13, 6'd1);
    measure_latency("lat_after_rst", 3);
    finish_run("t_after_rst", 10);

    // Start while busy is ignored
    set_entry(14, OP_DIV, 32'd50, 32'd5);
    expect_res(14, 64'd10, 1'b0);
    run(5'd14, 6'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    first_ptr = 5'd20;
    count     = 6'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_during_div", 128'(busy), 128'(1));
    finish_run("t_busy_start", 60);
    repeat (5) @(posedge clk);
    #1;
    check("busy_start_no_valid", 128'(res_valid), 128'(0));
    check("busy_start_idle",     128'(busy),      128'(0));

    // count == 0
    run(5'd7, 6'd0);
    check("cnt0_done_next", 128'(done),      128'(1));
    check("cnt0_busy",      128'(busy),      128'(0));
    check("cnt0_no_valid",  128'(res_valid), 128'(0));
    finish_run("t_cnt0", 2);
    check("cnt0_valid_after", 128'(res_valid), 128'(0));

    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
